// File: rtl/cpu_pkg.sv
// Shared CPU types: word/address widths, prefetch FSM states, FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } pf_state_t;

    // One buffered instruction/operand byte together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Generic synchronous FIFO with clear, single pop and (optionally) double pop.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none internally; the writer must never push into a full FIFO.
// Ports: clk/rst, clear_i (drops all entries, wins over push/pop), push_i/push_dat_i,
//        pop_i, count_o (occupancy), count_nxt_o (occupancy after this edge), head_o.
// Optional (macro PREFETCH_PEEK2_EN): pop2_i (consumes two entries), head2_o (head+1).
module pf_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
`ifdef PREFETCH_PEEK2_EN
    input  logic          pop2_i,
    output logic [W-1:0]  head2_o,
`endif
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_nxt_o,
    output logic [W-1:0]  head_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop1, do_pop2;

    // A double pop only happens with at least two entries; it takes precedence
    // over a single pop issued in the same cycle.
`ifdef PREFETCH_PEEK2_EN
    assign do_pop2 = pop2_i && (count_q >= CW'(2));
`else
    assign do_pop2 = 1'b0;
`endif
    assign do_pop1 = pop_i && !do_pop2 && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop2) begin
                rd_ptr_d = rd_ptr_q + PW'(2);
            end else if (do_pop1) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_i) - (do_pop2 ? CW'(2) : CW'(do_pop1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    assign count_o     = count_q;
    assign count_nxt_o = count_d;
    assign head_o      = mem_q[rd_ptr_q];

`ifdef PREFETCH_PEEK2_EN
    logic [PW-1:0] rd_ptr_p1;
    assign rd_ptr_p1 = rd_ptr_q + PW'(1);
    assign head2_o   = mem_q[rd_ptr_p1];
`endif

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch: fetches sequential bytes from program RAM into a small FIFO.
// Latency: REQ->grant->RESP, byte visible at FIFO head the cycle after RESP (3 cycles from reset).
// Backpressure: stops requesting while the FIFO is full; consumer drains via pop.
// Ports: clk/rst (sync, active-high); ram_req/ram_addr/ram_gnt/ram_rdata to the RAM arbiter;
//        instr_valid/instr_data/instr_addr + pop to the controller; flush/flush_addr redirect;
//        fifo_count occupancy.
// Optional (macro PREFETCH_PEEK2_EN): instr_valid2/instr_data2/instr_addr2 (head+1), pop2.
module instr_prefetch_unit #(
    parameter  int                 WORD_SIZE = cpu_pkg::WORD_SIZE,
    parameter  int                 ADDR_W    = cpu_pkg::ADDR_W,
    parameter  int                 DEPTH     = 4,
    parameter  logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
    localparam int                 CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ram_req,
    output logic [ADDR_W-1:0]    ram_addr,
    input  logic                 ram_gnt,
    input  logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [ADDR_W-1:0]    instr_addr,
`ifdef PREFETCH_PEEK2_EN
    output logic                 instr_valid2,
    output logic [WORD_SIZE-1:0] instr_data2,
    output logic [ADDR_W-1:0]    instr_addr2,
    input  logic                 pop2,
`endif
    input  logic                 pop,
    input  logic                 flush,
    input  logic [ADDR_W-1:0]    flush_addr,
    output logic [CW-1:0]        fifo_count
);

    import cpu_pkg::*;

    pf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] issued_q, issued_d;
    logic              drop_q, drop_d;
    logic              push;
    logic [CW-1:0]     count, count_nxt;
    fifo_entry_t       push_ent, head_ent;

    // fetch_pc only moves on a grant (which leaves REQ) or a flush, so the
    // address stays stable during a grant stall.
    assign ram_req  = (state_q == REQ);
    assign ram_addr = fetch_pc_q;

    // The response is pushed unless it belongs to a request overtaken by a flush.
    assign push     = (state_q == RESP) && !drop_q && !flush;
    assign push_ent = '{addr: issued_q, data: ram_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issued_d   = issued_q;
        drop_d     = drop_q;
        case (state_q)
            IDLE: begin
                if (count < CW'(DEPTH)) state_d = REQ;
            end
            REQ: begin
                if (ram_gnt) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    issued_d   = fetch_pc_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                drop_d  = 1'b0;
                state_d = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything. A grant taken on the flush edge still
        // returns data next cycle, so that response is marked for discard.
        if (flush) begin
            fetch_pc_d = flush_addr;
            if ((state_q == REQ) && ram_gnt) begin
                state_d = RESP;
                drop_d  = 1'b1;
            end else begin
                state_d = REQ;
                drop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            issued_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            issued_q   <= issued_d;
            drop_q     <= drop_d;
        end
    end

`ifdef PREFETCH_PEEK2_EN
    fifo_entry_t head2_ent;
`endif

    pf_fifo #(
        .W     ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .push_i      (push),
        .push_dat_i  (push_ent),
        .pop_i       (pop),
`ifdef PREFETCH_PEEK2_EN
        .pop2_i      (pop2),
        .head2_o     (head2_ent),
`endif
        .count_o     (count),
        .count_nxt_o (count_nxt),
        .head_o      (head_ent)
    );

    assign instr_valid = (count != '0);
    assign instr_data  = head_ent.data;
    assign instr_addr  = head_ent.addr;
    assign fifo_count  = count;

`ifdef PREFETCH_PEEK2_EN
    assign instr_valid2 = (count >= CW'(2));
    assign instr_data2  = head2_ent.data;
    assign instr_addr2  = head2_ent.addr;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit (default build).
// Reference model: queue of buffered addresses, modelled fetch address and one pending response.
// Directed scenarios followed by a randomized run with grant stalls, pops, flushes and resets.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, ram_req, ram_gnt, instr_valid, pop, flush;
    logic [7:0] ram_addr, ram_rdata, instr_data, instr_addr, flush_addr;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    instr_prefetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ram_req     (ram_req),
        .ram_addr    (ram_addr),
        .ram_gnt     (ram_gnt),
        .ram_rdata   (ram_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .pop         (pop),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .fifo_count  (fifo_count)
    );

    logic [7:0] mem [256];
    int         n_chk = 0;
    int         n_pass = 0;

    // Reference model state
    logic [7:0] exp_q [$];      // addresses currently expected in the FIFO, head first
    logic [7:0] m_pc;           // next address the unit should request
    bit         m_pend;         // a granted read whose data arrives this cycle
    logic [7:0] m_pend_addr;
    bit         chk_en;
    bit         prev_stall;
    logic [7:0] prev_addr;
    logic [7:0] popped_a [$];
    logic [7:0] popped_d [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge with inputs already set: check outputs, advance model, run one clock.
    task automatic tick();
        bit         acc;
        bit         pend_now;
        logic [7:0] acc_addr;
        if (chk_en) begin
            chk("count", 32'(fifo_count), exp_q.size());
            chk("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("head_addr", 32'(instr_addr), 32'(exp_q[0]));
                chk("head_data", 32'(instr_data), 32'(mem[exp_q[0]]));
            end
            if (ram_req === 1'b1) begin
                chk("req_addr", 32'(ram_addr), 32'(m_pc));
                chk("req_not_full", 32'(exp_q.size() < DEPTH), 32'd1);
            end
            if (m_pend) chk("req_during_resp", 32'(ram_req), 32'd0);
            if (prev_stall) begin
                chk("stall_req", 32'(ram_req), 32'd1);
                chk("stall_addr", 32'(ram_addr), 32'(prev_addr));
            end
        end
        acc        = (ram_req === 1'b1) && ram_gnt;
        acc_addr   = ram_addr;
        pend_now   = m_pend;
        prev_stall = (ram_req === 1'b1) && !ram_gnt && !flush && !rst;
        prev_addr  = ram_addr;
        if (pop && instr_valid && !rst && !flush) begin
            popped_a.push_back(instr_addr);
            popped_d.push_back(instr_data);
        end
        if (rst) begin
            exp_q.delete();
            m_pc   = 8'h00;
            m_pend = 1'b0;
        end else if (flush) begin
            exp_q.delete();
            m_pc   = flush_addr;
            m_pend = 1'b0;
        end else begin
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (pend_now) exp_q.push_back(m_pend_addr);
            m_pend = acc;
            if (acc) begin
                m_pend_addr = m_pc;
                m_pc        = m_pc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        ram_rdata = (acc && !rst) ? mem[acc_addr] : 8'($urandom);
        @(negedge clk);
    endtask

    initial begin
        int first;
        bit found;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[8'h40] = 8'h5A;
        rst = 1'b1; ram_gnt = 1'b1; pop = 1'b0; flush = 1'b0; flush_addr = 8'h00;
        ram_rdata = 8'h00; chk_en = 1'b0;
        m_pc = 8'h00; m_pend = 1'b0; m_pend_addr = 8'h00;
        @(negedge clk);
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(ram_req), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'h00);
        chk("rst_idata", 32'(instr_data), 32'h00);
        chk("rst_iaddr", 32'(instr_addr), 32'h00);
        rst = 1'b0;

        // 1. Sequential fill with grant tied high, no pop
        first = -1;
        for (int i = 0; i < 13; i++) begin
            if (instr_valid && first < 0) first = i;
            tick();
        end
        chk("first_valid_not_early", 32'(first >= 3), 32'd1);
        chk("first_valid_bounded", 32'(first <= 6), 32'd1);
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_req_idle", 32'(ram_req), 32'd0);
        chk("fill_head_data", 32'(instr_data), 32'h11);
        chk("fill_head_addr", 32'(instr_addr), 32'h00);

        // 2. Pop streaming
        popped_a.delete(); popped_d.delete();
        pop = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("stream_progress", 32'(popped_a.size() >= 6), 32'd1);
        for (int k = 0; k < popped_a.size() && k < 8; k++) begin
            chk("stream_addr", 32'(popped_a[k]), k);
            chk("stream_data", 32'(popped_d[k]), 32'(mem[k]));
        end

        // 3. Grant stall while requesting
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ram_req) found = 1'b1; else tick();
        end
        chk("stall_found_req", 32'(found), 32'd1);
        ram_gnt = 1'b0;
        a = ram_addr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gstall_req", 32'(ram_req), 32'd1);
            chk("gstall_addr", 32'(ram_addr), 32'(a));
        end
        ram_gnt = 1'b1;
        tick();
        chk("gstall_accepted", 32'(m_pend), 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // 4. Flush on the grant cycle of address 0x02
        pop = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ram_req && ram_addr == 8'h02) found = 1'b1; else tick();
        end
        chk("flush_found_req2", 32'(found), 32'd1);
        flush = 1'b1; flush_addr = 8'h40;
        tick();
        flush = 1'b0;
        chk("flush_cleared", 32'(instr_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (instr_valid) found = 1'b1; else tick();
        end
        chk("flush_refill", 32'(found), 32'd1);
        chk("flush_head_addr", 32'(instr_addr), 32'h40);
        chk("flush_head_data", 32'(instr_data), 32'h5A);

        // 5. Address wrap-around
        rst = 1'b1;
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC;
        tick();
        rst = 1'b0; flush = 1'b1; flush_addr = 8'hFE;
        tick();
        flush = 1'b0; pop = 1'b1;
        popped_a.delete(); popped_d.delete();
        for (int i = 0; i < 12; i++) tick();
        chk("wrap_progress", 32'(popped_a.size() >= 3), 32'd1);
        if (popped_a.size() >= 3) begin
            chk("wrap_a0", 32'(popped_a[0]), 32'hFE); chk("wrap_d0", 32'(popped_d[0]), 32'hAA);
            chk("wrap_a1", 32'(popped_a[1]), 32'hFF); chk("wrap_d1", 32'(popped_d[1]), 32'hBB);
            chk("wrap_a2", 32'(popped_a[2]), 32'h00); chk("wrap_d2", 32'(popped_d[2]), 32'hCC);
        end

        // 6. Reset while a response is arriving
        pop = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_pend) found = 1'b1; else tick();
        end
        chk("rresp_found", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rresp_count", 32'(fifo_count), 32'd0);
        chk("rresp_valid", 32'(instr_valid), 32'd0);
        chk("rresp_req", 32'(ram_req), 32'd0);
        chk("rresp_addr", 32'(ram_addr), 32'h00);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (ram_req) found = 1'b1; else tick();
        end
        chk("rresp_restart", 32'(found), 32'd1);
        chk("rresp_restart_addr", 32'(ram_addr), 32'h00);

        // 7. Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            ram_gnt    = ($urandom_range(0, 2) != 0);
            pop        = ($urandom_range(0, 1) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            flush_addr = 8'($urandom);
            rst        = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; pop = 1'b0; ram_gnt = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
